// File: rtl/accel_seq_ctrl_pkg.sv
// Package: accel_seq_ctrl_pkg
// Shared definitions for the accelerator tile sequencer:
//   - state_e      : FSM state encodings ST_IDLE..ST_POST
//   - MODE_*       : post-processing mode codes (11 is treated as raw)
//   - dp_en_t      : bundle of registered datapath enables / host readies
//   - mode_latency : post-buffer latency of the selected mode
//   - is_beat_phase: states whose length is counted by the beat counter
//   - decode_en    : enable decode of a state
`timescale 1ns/1ps
package accel_seq_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD_W  = 4'd1,
      ST_LOAD_A  = 4'd2,
      ST_PRELOAD = 4'd3,
      ST_STREAM  = 4'd4,
      ST_FLUSH   = 4'd5,
      ST_CAPTURE = 4'd6,
      ST_DRAIN   = 4'd7,
      ST_POST    = 4'd8
   } state_e;

   localparam logic [1:0] MODE_RAW     = 2'b00;
   localparam logic [1:0] MODE_RELU    = 2'b01;
   localparam logic [1:0] MODE_SOFTMAX = 2'b10;

   typedef struct packed {
      logic wgt_ready;
      logic act_ready;
      logic wb_out;
      logic write_w;
      logic ib_out;
      logic ob_load;
      logic ob_out;
      logic relu;
      logic softmax;
   } dp_en_t;

   // Cycles from output_buffer_out_en to a valid result row for a mode.
   function automatic int mode_latency(input logic [1:0] mode, input int buf_lat,
                                       input int relu_lat, input int sm_lat);
      int lat;
      case (mode)
         MODE_RELU:    lat = buf_lat + relu_lat;
         MODE_SOFTMAX: lat = buf_lat + sm_lat;
         default:      lat = buf_lat;
      endcase
      return lat;
   endfunction

   function automatic logic is_beat_phase(input state_e st);
      logic r;
      case (st)
         ST_LOAD_W, ST_LOAD_A, ST_PRELOAD,
         ST_STREAM, ST_CAPTURE, ST_DRAIN: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

   // Enables asserted while the FSM sits in a given state.
   function automatic dp_en_t decode_en(input state_e st, input logic [1:0] mode);
      dp_en_t en;
      en = '0;
      case (st)
         ST_LOAD_W:  en.wgt_ready = 1'b1;
         ST_LOAD_A:  en.act_ready = 1'b1;
         ST_PRELOAD: begin
            en.wb_out  = 1'b1;
            en.write_w = 1'b1;
         end
         ST_STREAM:  en.ib_out  = 1'b1;
         ST_CAPTURE: en.ob_load = 1'b1;
         ST_DRAIN:   en.ob_out  = 1'b1;
         default:    en = '0;
      endcase
      // post-processing stays enabled until the last row has left the pipe
      en.relu    = ((st == ST_DRAIN) || (st == ST_POST)) && (mode == MODE_RELU);
      en.softmax = ((st == ST_DRAIN) || (st == ST_POST)) && (mode == MODE_SOFTMAX);
      return en;
   endfunction

endpackage

// File: rtl/accel_seq_ctrl_phase_cnt.sv
// Module: accel_phase_cnt
// Loadable down-counter used to time the sequencer phases.
//   clk, rst   : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (highest priority)
//   load_i     : load load_val_i
//   en_i       : decrement by one (holds at zero)
//   zero_o     : count is zero
`timescale 1ns/1ps
module accel_phase_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // count register: clear > load > decrement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= {W{1'b0}};
      end else if (clr_i) begin
         cnt_q <= {W{1'b0}};
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != {W{1'b0}})) begin
         cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/accel_seq_ctrl.sv
// Module: accel_seq_ctrl
// Tile sequencer of the matrix accelerator. One start pulse runs a tile:
// load weights, load activations, preload, stream, flush, capture, drain,
// then waits for the post-processing pipe to empty and pulses done.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, abort              tile start (IDLE only), synchronous abort
//   cfg_mode, cfg_reuse_w     mode and weight-reuse request, latched on start
//   wgt_valid/wgt_ready       host weight beat handshake
//   act_valid/act_ready       host activation beat handshake
//   *_en                      datapath enables of the accelerator top
//   out_valid, busy, done     result row valid, tile in flight, completion pulse
//   w_resident                array holds a complete preloaded weight set
`timescale 1ns/1ps
module accel_seq_ctrl
   import accel_seq_ctrl_pkg::*;
#(
   parameter int ARRAY_W   = 8,
   parameter int FLUSH_CYC = 15,
   parameter int BUF_LAT   = 1,
   parameter int RELU_LAT  = 1,
   parameter int SM_LAT    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] cfg_mode,
   input  logic       cfg_reuse_w,
   input  logic       wgt_valid,
   output logic       wgt_ready,
   input  logic       act_valid,
   output logic       act_ready,
   output logic       input_buffer_load_en,
   output logic       input_buffer_out_en,
   output logic       weight_buffer_load_en,
   output logic       weight_buffer_out_en,
   output logic       output_buffer_load_en,
   output logic       output_buffer_out_en,
   output logic       write_weight_en,
   output logic       relu_en,
   output logic       softmax_en,
   output logic       out_valid,
   output logic       busy,
   output logic       done,
   output logic       w_resident
);

   localparam int BEAT_W  = $clog2(ARRAY_W + 1);
   localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
   localparam int PIPE_D  = BUF_LAT + SM_LAT;
   // counters run from N-1 down to 0, the phase ends on the zero cycle
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(ARRAY_W - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

   state_e            state_q, state_d;
   dp_en_t            en_q, en_d;
   logic [1:0]        mode_q, mode_d;
   logic              reuse_q, reuse_d;
   logic              w_res_q, w_res_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [PIPE_D-1:0] pipe_q, pipe_d;
   logic              out_valid_q, out_valid_d;

   logic              cnt_clr, beat_load, beat_en, beat_zero;
   logic              flush_load, flush_en, flush_zero;
   logic              wgt_fire, act_fire;
   logic [PIPE_D-1:0] tap_mask, low_mask;
   logic              pipe_empty;
   int                lat;

   assign wgt_fire = wgt_valid & en_q.wgt_ready;
   assign act_fire = act_valid & en_q.act_ready;

   accel_phase_cnt #(.W(BEAT_W)) u_beat_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .load_i     (beat_load),
      .load_val_i (BEAT_LAST),
      .en_i       (beat_en),
      .zero_o     (beat_zero)
   );

   accel_phase_cnt #(.W(FLUSH_W)) u_flush_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .load_i     (flush_load),
      .load_val_i (FLUSH_LAST),
      .en_i       (flush_en),
      .zero_o     (flush_zero)
   );

   // out_valid tap and pipe-empty window for the latched mode
   always_comb begin
      lat      = mode_latency(mode_q, BUF_LAT, RELU_LAT, SM_LAT);
      tap_mask = {PIPE_D{1'b0}};
      low_mask = {PIPE_D{1'b0}};
      for (int k = 0; k < PIPE_D; k++) begin
         tap_mask[k] = (k == (lat - 1));
         low_mask[k] = (k < lat);
      end
      pipe_empty = ~|(pipe_q & low_mask);
   end

   // next-state, latched configuration and counter control
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      reuse_d  = reuse_q;
      w_res_d  = w_res_q;
      done_d   = 1'b0;
      cnt_clr  = 1'b0;
      beat_en  = 1'b0;
      flush_en = 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
         // a partially written weight set is no longer trustworthy
         if ((state_q == ST_LOAD_W) || (state_q == ST_PRELOAD)) begin
            w_res_d = 1'b0;
         end else begin
            w_res_d = w_res_q;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  mode_d  = cfg_mode;
                  reuse_d = cfg_reuse_w & w_res_q;
                  state_d = (cfg_reuse_w & w_res_q) ? ST_LOAD_A : ST_LOAD_W;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD_W: begin
               beat_en = wgt_fire;
               if (wgt_fire && beat_zero) state_d = ST_LOAD_A;
               else                       state_d = ST_LOAD_W;
            end
            ST_LOAD_A: begin
               beat_en = act_fire;
               if (act_fire && beat_zero) state_d = reuse_q ? ST_STREAM : ST_PRELOAD;
               else                       state_d = ST_LOAD_A;
            end
            ST_PRELOAD: begin
               beat_en = 1'b1;
               if (beat_zero) begin
                  state_d = ST_STREAM;
                  w_res_d = 1'b1;
               end else begin
                  state_d = ST_PRELOAD;
               end
            end
            ST_STREAM: begin
               beat_en = 1'b1;
               state_d = beat_zero ? ST_FLUSH : ST_STREAM;
            end
            ST_FLUSH: begin
               flush_en = 1'b1;
               state_d  = flush_zero ? ST_CAPTURE : ST_FLUSH;
            end
            ST_CAPTURE: begin
               beat_en = 1'b1;
               state_d = beat_zero ? ST_DRAIN : ST_CAPTURE;
            end
            ST_DRAIN: begin
               beat_en = 1'b1;
               state_d = beat_zero ? ST_POST : ST_DRAIN;
            end
            ST_POST: begin
               if (pipe_empty) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_POST;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   assign beat_load  = (state_d != state_q) && is_beat_phase(state_d);
   assign flush_load = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

   // outputs are decoded from the next state so they line up with the state register
   always_comb begin
      en_d        = decode_en(state_d, mode_d);
      busy_d      = (state_d != ST_IDLE);
      if (cnt_clr) begin
         pipe_d      = {PIPE_D{1'b0}};
         out_valid_d = 1'b0;
      end else begin
         pipe_d      = {pipe_q[PIPE_D-2:0], en_d.ob_out};
         out_valid_d = |(pipe_q & tap_mask);
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         en_q        <= '0;
         mode_q      <= MODE_RAW;
         reuse_q     <= 1'b0;
         w_res_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pipe_q      <= {PIPE_D{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         mode_q      <= mode_d;
         reuse_q     <= reuse_d;
         w_res_q     <= w_res_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pipe_q      <= pipe_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign wgt_ready             = en_q.wgt_ready;
   assign act_ready             = en_q.act_ready;
   assign weight_buffer_load_en = wgt_fire;
   assign input_buffer_load_en  = act_fire;
   assign weight_buffer_out_en  = en_q.wb_out;
   assign write_weight_en       = en_q.write_w;
   assign input_buffer_out_en   = en_q.ib_out;
   assign output_buffer_load_en = en_q.ob_load;
   assign output_buffer_out_en  = en_q.ob_out;
   assign relu_en               = en_q.relu;
   assign softmax_en            = en_q.softmax;
   assign out_valid             = out_valid_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign w_resident            = w_res_q;

endmodule
